// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one imem request in flight
// and presents each fetched word with its PC to decode over valid/ready.
module ysyx_220053_ifu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            discard_reg, discard_next;
  logic            halt_pend_reg, halt_pend_next;
  logic            id_valid_reg, id_valid_next;
  logic [31:0]     id_instr_reg, id_instr_next;
  logic [XLEN-1:0] id_pc_reg, id_pc_next;
  logic            id_fault_reg, id_fault_next;
  logic            halted_reg, halted_next;

  logic            stop;
  logic            steer;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_inc;

  // A halt seen this cycle already outranks a simultaneous redirect.
  assign stop            = halt | halt_pend_reg;
  assign steer           = redirect_valid & ~stop;
  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign pc_inc          = pc_reg + XLEN'(4);

  // Held low while reset is asserted so memory never sees a request during reset.
  assign imem_req_valid = rst_n & (state_reg == S_REQ);
  assign imem_req_addr  = pc_reg;

  assign id_valid = id_valid_reg;
  assign id_instr = id_instr_reg;
  assign id_pc    = id_pc_reg;
  assign id_fault = id_fault_reg;
  assign halted   = halted_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    discard_next   = discard_reg;
    halt_pend_next = halt_pend_reg | halt;
    id_valid_next  = id_valid_reg;
    id_instr_next  = id_instr_reg;
    id_pc_next     = id_pc_reg;
    id_fault_next  = id_fault_reg;
    halted_next    = halted_reg;

    case (state_reg)
      S_REQ: begin
        if (steer) begin
          pc_next = redirect_target;
        end
        if (imem_req_ready) begin
          // The old address is already accepted; its response must be swallowed.
          state_next = S_WAIT;
          if (stop || steer) begin
            discard_next = 1'b1;
          end
        end else if (stop) begin
          state_next  = S_HALT;
          halted_next = 1'b1;
        end
      end

      S_WAIT: begin
        if (steer) begin
          pc_next = redirect_target;
        end
        if (imem_rsp_valid) begin
          if (discard_reg || stop || steer) begin
            discard_next = 1'b0;
            if (stop) begin
              state_next  = S_HALT;
              halted_next = 1'b1;
            end else begin
              state_next = S_REQ;
            end
          end else begin
            id_valid_next = 1'b1;
            id_instr_next = imem_rsp_err ? 32'h0 : imem_rsp_data;
            id_pc_next    = pc_reg;
            id_fault_next = imem_rsp_err;
            state_next    = S_OUT;
          end
        end else if (stop || steer) begin
          discard_next = 1'b1;
        end
      end

      S_OUT: begin
        if (stop) begin
          id_valid_next = 1'b0;
          state_next    = S_HALT;
          halted_next   = 1'b1;
        end else if (steer) begin
          // Any handshake this cycle still completes; the redirect wins over pc+4.
          id_valid_next = 1'b0;
          pc_next       = redirect_target;
          state_next    = S_REQ;
        end else if (id_ready) begin
          id_valid_next = 1'b0;
          pc_next       = pc_inc;
          state_next    = S_REQ;
        end
      end

      S_HALT: begin
        id_valid_next = 1'b0;
        halted_next   = 1'b1;
      end

      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_REQ;
      pc_reg        <= RESET_PC;
      discard_reg   <= 1'b0;
      halt_pend_reg <= 1'b0;
      id_valid_reg  <= 1'b0;
      id_instr_reg  <= 32'h0;
      id_pc_reg     <= '0;
      id_fault_reg  <= 1'b0;
      halted_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      discard_reg   <= discard_next;
      halt_pend_reg <= halt_pend_next;
      id_valid_reg  <= id_valid_next;
      id_instr_reg  <= id_instr_next;
      id_pc_reg     <= id_pc_next;
      id_fault_reg  <= id_fault_next;
      halted_reg    <= halted_next;
    end
  end

endmodule

// File: doc/ysyx_220053_ifu.md
Name: ysyx_220053_ifu

Overview:
- Instruction fetch unit for the single-issue NPC core; the producer side of the decoder's instruction input.
- Holds the PC, issues one request at a time to instruction memory, and presents each fetched word with its PC to decode over a valid/ready handshake.
- Accepts PC redirects from execute and stops fetching permanently when decode reports ebreak.

Parameters:
- XLEN, 64, width of PC and memory address.
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  XLEN  fetch address, always equal to pc.
- imem_rsp_valid  input  1  response word valid; one cycle per request.
- imem_rsp_data  input  32  instruction word.
- imem_rsp_err  input  1  access fault for this response.
- id_valid  output  1  instruction available to decode.
- id_ready  input  1  decode consumes the instruction this cycle.
- id_instr  output  32  instruction word to decode.
- id_pc  output  XLEN  PC of id_instr.
- id_fault  output  1  id_instr came from a faulting fetch.
- redirect_valid  input  1  one-cycle pulse; replace the PC.
- redirect_pc  input  XLEN  new PC; bits [1:0] are ignored and forced to 0.
- halt  input  1  ebreak committed; stop fetching.
- halted  output  1  IFU is stopped.

Behaviour:
- Reset: rst_n=0 at a rising edge sets pc=RESET_PC, state=REQ, discard=0, halt_pend=0. It also sets id_valid=0, id_instr=0, id_pc=0, id_fault=0, imem_req_valid=0 and halted=0. Reset mid-operation abandons any outstanding request. imem shares rst_n, so no stale response follows reset.
- Outputs are registered except imem_req_valid and imem_req_addr, which are decoded from state and pc.
- FSM states: REQ, WAIT, OUT, HALT.
- REQ:
  - imem_req_valid=1.
  - On imem_req_ready, go to WAIT.
  - imem_req_addr may change before acceptance (permitted by the imem protocol).
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with discard=0: latch id_instr=rsp_data (0 if rsp_err), id_pc=pc, id_fault=rsp_err. Set id_valid=1 and go to OUT.
  - On imem_rsp_valid with discard=1: drop the word, clear discard, go to REQ (or HALT if halt_pend).
  - imem_rsp_valid in any state other than WAIT is ignored.
- OUT:
  - id_valid held and outputs stable until id_ready.
  - On id_ready: id_valid=0, pc<=pc+4 (wraps modulo 2^XLEN), go to REQ.
- Minimum throughput: one instruction per 3 cycles (REQ->WAIT->OUT with 0-latency memory).
- Redirect, when not halted or halt_pend:
  - Always sets pc<=redirect_pc in the same edge.
  - REQ without ready: stay in REQ with the new address.
  - REQ with ready in the same cycle: the request with the old address is accepted; set discard=1; go to WAIT.
  - WAIT: set discard=1; a response arriving in the same cycle is dropped, and the FSM goes to REQ.
  - OUT: id_valid<=0 and go to REQ. If id_ready is high in the same cycle, decode's handshake still completes, and redirect_pc takes priority over pc+4.
- Halt (priority over redirect):
  - Halt is sampled every cycle; once seen, halt_pend is set and stays set.
  - REQ without ready: go to HALT at once.
  - REQ with ready: go to WAIT with discard=1, then HALT on the response.
  - WAIT: set discard=1 and go to HALT on the response.
  - OUT: id_valid<=0 and go to HALT.
- HALT: no requests, id_valid=0, halted=1. Only reset exits.
- pc[1:0] is always 0.

Test Plan:
- Reset then straight-line fetch, memory ready every cycle and words 0x00100093, 0x00200113 -> id_pc=0x80000000 then 0x80000004, correct instr, 3 cycles apart; imem_req_addr matches.
- Decode backpressure: id_ready low 5 cycles -> id_valid/id_instr/id_pc stable, no new imem request, pc advances only after id_ready.
- Redirect in WAIT to 0x80000100 with the response in the same cycle -> word dropped, next request addr 0x80000100, next id_pc=0x80000100. Repeat in REQ with imem_req_ready=1 -> one extra response absorbed, never shown to decode.
- imem_rsp_err=1 on fetch at 0x80000008 -> id_fault=1, id_instr=0, id_pc=0x80000008; the next fetch proceeds normally.
- halt pulse while a request is outstanding and redirect asserted in the same cycle -> response dropped, halted=1, imem_req_valid stays 0 for 50 cycles, redirect ignored; rst_n low one cycle -> fetch restarts at 0x80000000, halted=0.
- rst_n low while in OUT -> next cycle id_valid=0, id_instr=0, state REQ, addr 0x80000000.
